pspin_stdout_arb: RTL

Collects 32-bit stdout words from NUM_REQ PsPIN requesters (cluster/core printf ports). Round-robin arbitration, one word per cycle, into a single FIFO. The FIFO feeds the stdout read port of the control-register block (0x1000). The read side is first-word-fall-through, matching that block's `stdout_rd_en` / `stdout_dout` / `stdout_data_valid` contract. Requesters are back-pressured, never dropped.

---
 rtl/pspin_stdout_arb.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pspin_stdout_arb.sv
// Round-robin collector of requester stdout words into one FIFO.
// The read side is first-word-fall-through.
module pspin_stdout_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 64,
  parameter int LVL_WIDTH  = $clog2(FIFO_DEPTH) + 1,
  localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int PTR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          stdout_rd_en,
  output logic [DATA_WIDTH-1:0]         stdout_dout,
  output logic                          stdout_data_valid,
  output logic [LVL_WIDTH-1:0]          fifo_level,
  output logic [IDX_W-1:0]              grant_idx
);

  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [LVL_WIDTH-1:0]  count_r;
  logic [IDX_W-1:0]      rr_ptr_r;
  logic [IDX_W-1:0]      grant_idx_r;

  logic [IDX_W:0]        cand_sum_s;
  logic [IDX_W-1:0]      win_idx_s;
  logic                  win_found_s;
  logic [DATA_WIDTH-1:0] win_data_s;
  logic                  space_s;
  logic                  push_s;
  logic                  pop_s;
  logic [IDX_W-1:0]      rr_next_s;

  // Winner search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    cand_sum_s  = '0;
    win_idx_s   = '0;
    win_found_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum_s = {1'b0, rr_ptr_r} + (IDX_W+1)'(k);
      if (cand_sum_s >= (IDX_W+1)'(NUM_REQ)) begin
        cand_sum_s = cand_sum_s - (IDX_W+1)'(NUM_REQ);
      end else begin
        cand_sum_s = cand_sum_s;
      end
      if (!win_found_s && req_valid[cand_sum_s[IDX_W-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_sum_s[IDX_W-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Data mux for the winning requester.
  always_comb begin
    win_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx_s == IDX_W'(i)) begin
        win_data_s = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        win_data_s = win_data_s;
      end
    end
  end

  // Handshake and pointer-advance decisions; a same-cycle pop never frees space.
  always_comb begin
    space_s   = (count_r != LVL_WIDTH'(FIFO_DEPTH)) && rst_n;
    push_s    = win_found_s && space_s;
    pop_s     = stdout_rd_en && (count_r != '0);
    req_ready = '0;
    if (push_s) begin
      req_ready[win_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
    if (win_idx_s == IDX_W'(NUM_REQ - 1)) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = win_idx_s + IDX_W'(1);
    end
  end

  // FIFO storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= win_data_s;
    end
  end

  // Pointers, occupancy, and arbitration state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      rr_ptr_r    <= '0;
      grant_idx_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r    <= wr_ptr_r + PTR_W'(1);
        rr_ptr_r    <= rr_next_s;
        grant_idx_r <= win_idx_s;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + LVL_WIDTH'(1);
        2'b01:   count_r <= count_r - LVL_WIDTH'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Read-side outputs taken straight from registered state.
  always_comb begin
    if (count_r != '0) begin
      stdout_dout = mem_r[rd_ptr_r];
    end else begin
      stdout_dout = '0;
    end
    stdout_data_valid = (count_r != '0);
    fifo_level        = count_r;
    grant_idx         = grant_idx_r;
  end

endmodule
